// File: rtl/mp_addsub_seq_if.sv
// Operand/result bundle for the chunked multi-precision adder/subtractor.
// The master (control FSM) issues start and operands; the slave returns busy/done/result.
interface mp_addsub_seq_if #(
    parameter int WIDTH = 514
);
    logic             start;
    logic             subtract;
    logic             shift;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   out_result;

    modport master (
        output start, subtract, shift, in_a, in_b,
        input  busy, done, out_result
    );

    modport slave (
        input  start, subtract, shift, in_a, in_b,
        output busy, done, out_result
    );
endinterface

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract, CHUNK bits per cycle through a registered carry,
// with optional halving (logical for add, arithmetic for subtract) of the WIDTH+1-bit result.
module mp_addsub_seq #(
    parameter int WIDTH = 514,
    parameter int CHUNK = 64
) (
    input  logic               clk,
    input  logic               resetn,
    mp_addsub_seq_if.slave     bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int EXTW   = NCHUNK * CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, shift_q;
    logic [EXTW-1:0]  a_q, b_q, acc_q, acc_d;
    logic [WIDTH:0]   result_q, result_d;
    logic [WIDTH:0]   raw;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   sum;
    logic [31:0]      base;
    logic             last;

    function automatic logic [WIDTH:0] halve(input logic [WIDTH:0] val, input logic arith);
        return {arith & val[WIDTH], val[WIDTH:1]};
    endfunction

    assign base = 32'(cnt_q) * 32'(CHUNK);
    assign last = (cnt_q == CNT_W'(NCHUNK - 1));
    assign a_ch = a_q[base +: CHUNK];
    assign b_ch = b_q[base +: CHUNK];
    assign sum  = {1'b0, a_ch} + {1'b0, b_ch ^ {CHUNK{sub_q}}} + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    carry_d = bus.subtract;
                end
            end
            CALC: begin
                acc_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d              = sum[CHUNK];
                cnt_d                = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = FIN;
                    cnt_d   = '0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With no padding bits, bit WIDTH comes from the final carry (a borrow flag when subtracting).
    if (EXTW > WIDTH) begin : g_pad
        assign raw = acc_d[WIDTH:0];
    end else begin : g_exact
        assign raw = {sum[CHUNK] ^ sub_q, acc_d};
    end

    // The result lands on the edge that enters FIN so it is valid together with done.
    always_comb begin
        result_d = result_q;
        if (state_q == CALC && last) begin
            result_d = shift_q ? halve(raw, sub_q) : raw;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        if (state_q == IDLE && bus.start) begin
            a_q     <= EXTW'(bus.in_a);
            b_q     <= EXTW'(bus.in_b);
            sub_q   <= bus.subtract;
            shift_q <= bus.shift;
        end
    end

    assign bus.busy       = (state_q == CALC);
    assign bus.done       = (state_q == FIN);
    assign bus.out_result = result_q;
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Bench for mp_addsub_seq in four widths/chunkings against a plain-arithmetic model.
module tb_mp_addsub_seq;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    mp_addsub_seq_if #(.WIDTH(514)) if0 ();
    mp_addsub_seq_if #(.WIDTH(514)) if1 ();
    mp_addsub_seq_if #(.WIDTH(33))  if2 ();
    mp_addsub_seq_if #(.WIDTH(8))   if3 ();

    mp_addsub_seq #(.WIDTH(514), .CHUNK(64))  u0 (.clk(clk), .resetn(resetn), .bus(if0));
    mp_addsub_seq #(.WIDTH(514), .CHUNK(514)) u1 (.clk(clk), .resetn(resetn), .bus(if1));
    mp_addsub_seq #(.WIDTH(33),  .CHUNK(8))   u2 (.clk(clk), .resetn(resetn), .bus(if2));
    mp_addsub_seq #(.WIDTH(8),   .CHUNK(3))   u3 (.clk(clk), .resetn(resetn), .bus(if3));

    always #5 clk = ~clk;

    function automatic logic [513:0] mask_w(input int w, input logic [513:0] x);
        logic [513:0] m;
        m = (514'(1) << w) - 514'(1);
        return x & m;
    endfunction

    function automatic logic [513:0] rnd_op(input int w);
        logic [513:0] v;
        v = '0;
        case ($urandom_range(7))
            0:       v = '0;
            1:       v = '1;
            default: for (int i = 0; i < 17; i++) v = (v << 32) | 514'($urandom());
        endcase
        return mask_w(w, v);
    endfunction

    // (a +/- b) mod 2^(w+1), optionally halved; sign bit w kept for subtraction.
    function automatic logic [515:0] ref_model(input int w, input logic [513:0] a, input logic [513:0] b,
                                               input logic sub, input logic sh);
        logic [515:0] m, raw, r;
        m   = (516'(1) << (w + 1)) - 516'(1);
        raw = (sub ? ({2'b00, a} - {2'b00, b}) : ({2'b00, a} + {2'b00, b})) & m;
        r   = raw;
        if (sh) begin
            r = raw >> 1;
            if (sub && raw[w]) r[w] = 1'b1;
        end
        return r;
    endfunction

    task automatic idle_all();
        if0.start = 1'b0; if0.subtract = 1'b0; if0.shift = 1'b0; if0.in_a = '0; if0.in_b = '0;
        if1.start = 1'b0; if1.subtract = 1'b0; if1.shift = 1'b0; if1.in_a = '0; if1.in_b = '0;
        if2.start = 1'b0; if2.subtract = 1'b0; if2.shift = 1'b0; if2.in_a = '0; if2.in_b = '0;
        if3.start = 1'b0; if3.subtract = 1'b0; if3.shift = 1'b0; if3.in_a = '0; if3.in_b = '0;
    endtask

    task automatic test_reset();
        idle_all();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            errors++; $display("FAIL reset_ctl0 busy=%b done=%b required 0 0", if0.busy, if0.done);
        end
        checks++;
        if (if0.out_result !== '0) begin
            errors++; $display("FAIL reset_result0 got %h required 0", if0.out_result);
        end
        checks++;
        if (if3.busy !== 1'b0 || if3.done !== 1'b0 || if3.out_result !== '0) begin
            errors++; $display("FAIL reset_u3 busy=%b done=%b res=%h required 0 0 0", if3.busy, if3.done, if3.out_result);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_carry_ripple();
        logic [514:0] expv;
        expv = 515'(1) << 514;
        if0.in_a = '1; if0.in_b = 514'(1); if0.subtract = 1'b0; if0.shift = 1'b0; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (if0.busy !== (c <= 9) || if0.done !== (c == 10)) begin
                errors++;
                $display("FAIL carry_timing cycle %0d busy=%b done=%b required %b %b", c, if0.busy, if0.done, (c <= 9), (c == 10));
            end
            if (c < 10) @(negedge clk);
        end
        checks++;
        if (if0.out_result !== expv) begin
            errors++; $display("FAIL carry_result got %h required %h", if0.out_result, expv);
        end
        @(negedge clk);
        checks++;
        if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.out_result !== expv) begin
            errors++; $display("FAIL carry_after done=%b busy=%b res=%h required 0 0 %h", if0.done, if0.busy, if0.out_result, expv);
        end
    endtask

    task automatic test_sub_small();
        logic [514:0] expv;
        int n;
        for (int sh = 0; sh < 2; sh++) begin
            expv = '1;
            if (sh == 0) expv[0] = 1'b0;
            if0.in_a = 514'(5); if0.in_b = 514'(7); if0.subtract = 1'b1; if0.shift = sh[0]; if0.start = 1'b1;
            @(negedge clk);
            if0.start = 1'b0;
            n = 1;
            while (if0.done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != 10) begin
                errors++; $display("FAIL sub_latency shift=%0d got %0d required 10", sh, n);
            end
            checks++;
            if (if0.out_result !== expv) begin
                errors++; $display("FAIL sub_result shift=%0d got %h required %h", sh, if0.out_result, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_small_configs();
        logic [513:0] a1, b1, a2, b2;
        logic         s1, h1, s2, h2;
        int           seen1, seen2, seen3;
        a1 = rnd_op(514); b1 = rnd_op(514); s1 = 1'($urandom_range(1)); h1 = 1'($urandom_range(1));
        a2 = rnd_op(33);  b2 = rnd_op(33);  s2 = 1'($urandom_range(1)); h2 = 1'($urandom_range(1));
        if1.in_a = a1; if1.in_b = b1; if1.subtract = s1; if1.shift = h1; if1.start = 1'b1;
        if2.in_a = a2[32:0]; if2.in_b = b2[32:0]; if2.subtract = s2; if2.shift = h2; if2.start = 1'b1;
        if3.in_a = 8'd200; if3.in_b = 8'd100; if3.subtract = 1'b0; if3.shift = 1'b1; if3.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
        seen1 = 0; seen2 = 0; seen3 = 0;
        for (int c = 1; c <= 8; c++) begin
            if (if1.done === 1'b1 && seen1 == 0) seen1 = c;
            if (if2.done === 1'b1 && seen2 == 0) seen2 = c;
            if (if3.done === 1'b1 && seen3 == 0) seen3 = c;
            @(negedge clk);
        end
        checks++;
        if (seen1 != 2 || seen2 != 6 || seen3 != 4) begin
            errors++; $display("FAIL small_latency got %0d/%0d/%0d required 2/6/4", seen1, seen2, seen3);
        end
        checks++;
        if (if3.out_result !== 9'd150) begin
            errors++; $display("FAIL w8_halve got %0d required 150", if3.out_result);
        end
        checks++;
        if (516'(if1.out_result) !== ref_model(514, a1, b1, s1, h1)) begin
            errors++; $display("FAIL w514_single got %h required %h", if1.out_result, ref_model(514, a1, b1, s1, h1));
        end
        checks++;
        if (516'(if2.out_result) !== ref_model(33, a2, b2, s2, h2)) begin
            errors++; $display("FAIL w33_result got %h required %h", if2.out_result, ref_model(33, a2, b2, s2, h2));
        end
    endtask

    task automatic test_start_while_busy();
        logic [513:0] qa [33];
        logic [513:0] qb [33];
        logic         qs [33];
        logic         qh [33];
        logic [514:0] prev;
        int           ndone, cyc, idx;
        ndone = 0;
        prev  = if0.out_result;
        for (int e = 0; e < 33; e++) begin
            qa[e] = rnd_op(514); qb[e] = rnd_op(514);
            qs[e] = 1'($urandom_range(1)); qh[e] = 1'($urandom_range(1));
            if0.in_a = qa[e]; if0.in_b = qb[e]; if0.subtract = qs[e]; if0.shift = qh[e]; if0.start = 1'b1;
            @(negedge clk);
            cyc = e + 1;
            if (if0.done === 1'b1) begin
                ndone++;
                checks++;
                if (cyc % 11 != 10) begin
                    errors++; $display("FAIL busy_done_timing done at cycle %0d required 10/21/32", cyc);
                end else begin
                    idx = cyc - 10;
                    checks++;
                    if (516'(if0.out_result) !== ref_model(514, qa[idx], qb[idx], qs[idx], qh[idx])) begin
                        errors++;
                        $display("FAIL busy_result cycle %0d got %h required %h", cyc, if0.out_result,
                                 ref_model(514, qa[idx], qb[idx], qs[idx], qh[idx]));
                    end
                end
            end else begin
                checks++;
                if (if0.out_result !== prev) begin
                    errors++; $display("FAIL busy_hold cycle %0d got %h required %h", cyc, if0.out_result, prev);
                end
            end
            prev = if0.out_result;
        end
        if0.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if0.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 3) begin
            errors++; $display("FAIL busy_done_count got %0d required 3", ndone);
        end
    endtask

    task automatic test_async_reset();
        logic [513:0] a, b;
        int           n, spurious;
        a = rnd_op(514); b = rnd_op(514);
        if0.in_a = a; if0.in_b = b; if0.subtract = 1'b0; if0.shift = 1'b0; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.out_result !== '0) begin
            errors++; $display("FAIL async_reset busy=%b done=%b res=%h required 0 0 0", if0.busy, if0.done, if0.out_result);
        end
        @(negedge clk);
        resetn = 1'b1;
        spurious = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if0.done !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++; $display("FAIL async_no_done got %0d pulses required 0", spurious);
        end
        a = rnd_op(514); b = rnd_op(514);
        if0.in_a = a; if0.in_b = b; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        n = 1;
        while (if0.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 10 || 516'(if0.out_result) !== ref_model(514, a, b, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL async_recover latency %0d res %h required 10 %h", n, if0.out_result, ref_model(514, a, b, 1'b0, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [513:0] a [4];
        logic [513:0] b [4];
        logic [515:0] res [4];
        int           nd [4];
        int           dc [4];
        int           wid [4];
        int           lat [4];
        logic         sub, sh;
        wid = '{514, 514, 33, 8};
        lat = '{10, 2, 6, 4};
        for (int v = 0; v < 3000; v++) begin
            sub = 1'($urandom_range(1));
            sh  = 1'($urandom_range(1));
            for (int k = 0; k < 4; k++) begin
                a[k] = rnd_op(wid[k]); b[k] = rnd_op(wid[k]); nd[k] = 0; dc[k] = 0;
            end
            if0.in_a = a[0];       if0.in_b = b[0];       if0.subtract = sub; if0.shift = sh; if0.start = 1'b1;
            if1.in_a = a[1];       if1.in_b = b[1];       if1.subtract = sub; if1.shift = sh; if1.start = 1'b1;
            if2.in_a = a[2][32:0]; if2.in_b = b[2][32:0]; if2.subtract = sub; if2.shift = sh; if2.start = 1'b1;
            if3.in_a = a[3][7:0];  if3.in_b = b[3][7:0];  if3.subtract = sub; if3.shift = sh; if3.start = 1'b1;
            @(negedge clk);
            if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
            if0.in_a = ~a[0]; if1.in_b = ~b[1]; if2.subtract = ~sub; if3.shift = ~sh;
            for (int c = 1; c <= 11; c++) begin
                if (if0.done === 1'b1) begin nd[0]++; dc[0] = c; end
                if (if1.done === 1'b1) begin nd[1]++; dc[1] = c; end
                if (if2.done === 1'b1) begin nd[2]++; dc[2] = c; end
                if (if3.done === 1'b1) begin nd[3]++; dc[3] = c; end
                if (c < 11) @(negedge clk);
            end
            res[0] = 516'(if0.out_result);
            res[1] = 516'(if1.out_result);
            res[2] = 516'(if2.out_result);
            res[3] = 516'(if3.out_result);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (nd[k] != 1 || dc[k] != lat[k]) begin
                    errors++;
                    $display("FAIL rand_timing vec %0d dut %0d dones %0d at %0d required 1 at %0d", v, k, nd[k], dc[k], lat[k]);
                end
                checks++;
                if (res[k] !== ref_model(wid[k], a[k], b[k], sub, sh)) begin
                    errors++;
                    $display("FAIL rand_result vec %0d dut %0d sub %b sh %b got %h required %h", v, k, sub, sh, res[k],
                             ref_model(wid[k], a[k], b[k], sub, sh));
                end
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_sub_small();
        test_small_configs();
        test_start_while_busy();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end
endmodule
